muldiv_unit: RTL and testbench

- Iterative multi-cycle execute unit for the RISC-V M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits beside the single-cycle ALU in the execute stage and consumes the same func3 field the ALU decoder inspects.
- Uses a start/busy/done handshake; the control unit stalls the PC while busy_o is high.
- Radix-2 shift-add multiply; restoring divide.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_unit_div_step.sv | 23 ++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  // Helper functions work on this width; DATA_WIDTH up to 64 keeps the product inside it.
  localparam int MAX_WIDTH = 128;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } muldiv_state_e;

  function automatic logic [MAX_WIDTH-1:0] negate(input logic [MAX_WIDTH-1:0] x);
    return ~x + MAX_WIDTH'(1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] abs_val(input logic [MAX_WIDTH-1:0] x,
                                                    input logic neg);
    return neg ? negate(x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift remainder:dividend left, trial-subtract the divisor.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dividend_o,
  output logic         q_bit_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted    = {rem_i, dividend_i[W-1]};
  assign diff       = shifted - {1'b0, divisor_i};
  // A clear borrow bit means the divisor fits into the partial remainder.
  assign q_bit_o    = ~diff[W];
  assign rem_o      = q_bit_o ? diff[W-1:0] : shifted[W-1:0];
  assign dividend_o = {dividend_i[W-2:0], 1'b0};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiply, restoring divide.
// Build option: define MULDIV_EARLY_OUT_EN to finish multiplies with a zero operand immediately.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            func3_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W) + 1;

  muldiv_state_e  state_reg, state_next;
  muldiv_op_e     op_reg, op_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2*W-1:0] acc_reg, acc_next;
  logic [W-1:0]   mcand_reg, mcand_next;
  logic           neg_reg, neg_next;
  logic           spec_reg, spec_next;
  logic [W-1:0]   result_reg, result_next;
  logic           done_reg, done_next;

  logic           a_signed, b_signed, neg_a, neg_b, b_zero, sgn_ovf;
  logic [W-1:0]   mag_a, mag_b, fin_result, quo_neg, rem_neg;
  logic [2*W-1:0] prod_neg, prod_fix, mul_acc;
  logic [W:0]     mul_sum;
  logic [W-1:0]   div_rem, div_dividend;
  logic           div_q;

  // Operand conditioning for the request presented on the inputs.
  assign a_signed = (func3_i == OP_MULH) || (func3_i == OP_MULHSU) || (func3_i[2] && !func3_i[0]);
  assign b_signed = (func3_i == OP_MULH) || (func3_i[2] && !func3_i[0]);
  assign neg_a    = a_signed & a_i[W-1];
  assign neg_b    = b_signed & b_i[W-1];
  assign mag_a    = W'(abs_val(MAX_WIDTH'(a_i), neg_a));
  assign mag_b    = W'(abs_val(MAX_WIDTH'(b_i), neg_b));
  assign b_zero   = (b_i == '0);
  assign sgn_ovf  = (a_i == {1'b1, {(W-1){1'b0}}}) && (&b_i);

  // Multiply: low half holds the remaining multiplier bits, high half the running sum.
  assign mul_sum = {1'b0, acc_reg[2*W-1:W]} + {1'b0, (acc_reg[0] ? mcand_reg : '0)};
  assign mul_acc = {mul_sum, acc_reg[W-1:1]};

  div_step #(.W(W)) u_div_step (
    .rem_i      (acc_reg[2*W-1:W]),
    .dividend_i (acc_reg[W-1:0]),
    .divisor_i  (mcand_reg),
    .rem_o      (div_rem),
    .dividend_o (div_dividend),
    .q_bit_o    (div_q)
  );

  assign prod_neg = (2*W)'(negate(MAX_WIDTH'(acc_reg)));
  assign prod_fix = neg_reg ? prod_neg : acc_reg;
  assign quo_neg  = W'(negate(MAX_WIDTH'(acc_reg[W-1:0])));
  assign rem_neg  = W'(negate(MAX_WIDTH'(acc_reg[2*W-1:W])));

  always_comb begin
    fin_result = acc_reg[W-1:0];
    if (!spec_reg) begin
      case (op_reg)
        OP_MUL:                        fin_result = prod_fix[W-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[2*W-1:W];
        OP_DIV, OP_DIVU:               fin_result = neg_reg ? quo_neg : acc_reg[W-1:0];
        default:                       fin_result = neg_reg ? rem_neg : acc_reg[2*W-1:W];
      endcase
    end
  end

  always_comb begin
    state_next  = state_reg;
    op_next     = op_reg;
    count_next  = count_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    neg_next    = neg_reg;
    spec_next   = spec_reg;
    result_next = result_reg;
    done_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        // The done cycle is not a legal accept cycle; the next request waits one more cycle.
        if (start_i && !done_reg) begin
          op_next    = muldiv_op_e'(func3_i);
          count_next = '0;
          mcand_next = mag_b;
          acc_next   = {{W{1'b0}}, mag_a};
          neg_next   = (func3_i[2] && func3_i[1]) ? neg_a : (neg_a ^ neg_b);
          spec_next  = 1'b0;
          state_next = func3_i[2] ? DIV : MUL;
          if (func3_i[2] && b_zero) begin
            spec_next  = 1'b1;
            acc_next   = {{W{1'b0}}, (func3_i[1] ? a_i : {W{1'b1}})};
            state_next = FIN;
          end else if (func3_i[2] && !func3_i[0] && sgn_ovf) begin
            spec_next  = 1'b1;
            acc_next   = {{W{1'b0}}, (func3_i[1] ? {W{1'b0}} : a_i)};
            state_next = FIN;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (!func3_i[2] && ((a_i == '0) || b_zero)) begin
            spec_next  = 1'b1;
            acc_next   = '0;
            state_next = FIN;
          end
`endif
        end
      end
      MUL: begin
        acc_next   = mul_acc;
        count_next = count_reg + 1'b1;
        if (count_reg == CNT_W'(W - 1)) state_next = FIN;
      end
      DIV: begin
        acc_next   = {div_rem, div_dividend | W'(div_q)};
        count_next = count_reg + 1'b1;
        if (count_reg == CNT_W'(W - 1)) state_next = FIN;
      end
      default: begin
        result_next = fin_result;
        done_next   = 1'b1;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= OP_MUL;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      neg_reg    <= 1'b0;
      spec_reg   <= 1'b0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      op_reg     <= op_next;
      count_reg  <= count_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      neg_reg    <= neg_next;
      spec_reg   <= spec_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  assign busy_o   = (state_reg != IDLE);
  assign done_o   = done_reg;
  assign result_o = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (32-bit); honours MULDIV_EARLY_OUT_EN.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  func3_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, done_o;
  logic [31:0] result_o;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .func3_i  (func3_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Issue one request and wait for done_o; lat is the cycle index of done_o (accept edge = 0).
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_n);
    busy_n = 0;
    @(posedge clk); #1;
    func3_i = f; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = '0; b_i = '0;
    lat = 1;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done_o) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout f=%b a=%h b=%h: done_o never rose within %0d cycles", f, a, b, lat);
    end
    res = result_o;
    $display("op f=%b a=%h b=%h -> result=%h latency=%0d", f, a, b, res, lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; func3_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_o); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul;
    logic [31:0] r; int lat, bn;
    run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, r, lat, bn);
    n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h want ffffffeb", r); end
    n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency: got %0d want 34", lat); end
    n_cmp++; if (bn != 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 33", bn); end
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mul_busy_at_done: got %b want 0", busy_o); end
  endtask

  task automatic test_mulh;
    logic [31:0] r; int lat, bn;
    run_op(F_MULH, 32'h8000_0000, 32'h8000_0000, r, lat, bn);
    n_cmp++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_result: got %h want 40000000", r); end
    n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL mulh_latency: got %0d want 34", lat); end
    run_op(F_MULHU, 32'h8000_0000, 32'h8000_0000, r, lat, bn);
    n_cmp++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulhu_result: got %h want 40000000", r); end
    run_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bn);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_result: got %h want ffffffff", r); end
    run_op(F_MULH, 32'hFFFF_FFFE, 32'd3, r, lat, bn);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulh_neg_result: got %h want ffffffff", r); end
  endtask

  task automatic test_div;
    logic [31:0] r; int lat, bn;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, r, lat, bn);
    n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_result: got %h want fffffffd", r); end
    n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL div_latency: got %0d want 34", lat); end
    run_op(F_REM, 32'hFFFF_FFF9, 32'd2, r, lat, bn);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_result: got %h want ffffffff", r); end
    run_op(F_DIVU, 32'd100, 32'd7, r, lat, bn);
    n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_result: got %h want 0000000e", r); end
    run_op(F_REMU, 32'd100, 32'd7, r, lat, bn);
    n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_result: got %h want 00000002", r); end
  endtask

  task automatic test_special;
    logic [31:0] r; int lat, bn;
    run_op(F_DIVU, 32'd5, 32'd0, r, lat, bn);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0_result: got %h want ffffffff", r); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL divu_by0_latency: got %0d want 2", lat); end
    run_op(F_REM, 32'd5, 32'd0, r, lat, bn);
    n_cmp++; if (r !== 32'd5) begin n_fail++; $display("FAIL rem_by0_result: got %h want 00000005", r); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL rem_by0_latency: got %0d want 2", lat); end
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bn);
    n_cmp++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_result: got %h want 80000000", r); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL div_ovf_latency: got %0d want 2", lat); end
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bn);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_ovf_result: got %h want 00000000", r); end
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL rem_ovf_latency: got %0d want 2", lat); end
  endtask

  task automatic test_handshake;
    int cyc, dones, lat;
    logic [31:0] r;
    dones = 0; lat = 0; r = '0;
    @(posedge clk); #1;
    func3_i = F_MUL; a_i = 32'd123; b_i = 32'd456; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      if (cyc == 5 || cyc == 20) begin
        start_i = 1'b1; func3_i = F_DIVU; a_i = 32'd1; b_i = 32'd1;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done_o) begin
        dones++;
        if (dones == 1) begin lat = cyc; r = result_o; end
      end
    end
    start_i = 1'b0;
    $display("handshake: dones=%0d latency=%0d result=%h", dones, lat, r);
    n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL hs_done_pulses: got %0d want 1", dones); end
    n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL hs_latency: got %0d want 34", lat); end
    n_cmp++; if (r !== 32'd56088) begin n_fail++; $display("FAIL hs_result: got %h want 0000db18", r); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r; int lat, bn;
    run_op(F_DIVU, 32'd77, 32'd7, r, lat, bn);
    n_cmp++; if (r !== 32'd11) begin n_fail++; $display("FAIL b2b_first_result: got %h want 0000000b", r); end
    // Still in the done cycle: a start here must be dropped.
    start_i = 1'b1; func3_i = F_MUL; a_i = 32'd2; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    $display("b2b: start during done cycle -> busy_o=%b done_o=%b", busy_o, done_o);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after_done: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %b want 0", done_o); end
    run_op(F_MUL, 32'd2, 32'd3, r, lat, bn);
    n_cmp++; if (r !== 32'd6) begin n_fail++; $display("FAIL b2b_second_result: got %h want 00000006", r); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] r; int lat, bn, dones;
    @(posedge clk); #1;
    func3_i = F_DIV; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("abort: busy_o=%b done_o=%b result_o=%h", busy_o, done_o, result_o);
    n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b want 0", done_o); end
    n_cmp++; if (result_o !== 32'h0) begin n_fail++; $display("FAIL abort_result: got %h want 0", result_o); end
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", dones); end
    run_op(F_MUL, 32'd6, 32'd7, r, lat, bn);
    n_cmp++; if (r !== 32'd42) begin n_fail++; $display("FAIL post_reset_mul_result: got %h want 0000002a", r); end
    n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL post_reset_mul_latency: got %0d want 34", lat); end
    run_op(F_MUL, 32'd0, 32'd9, r, lat, bn);
    n_cmp++; if (r !== 32'd0) begin n_fail++; $display("FAIL zero_mul_result: got %h want 00000000", r); end
`ifdef MULDIV_EARLY_OUT_EN
    n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL zero_mul_latency: got %0d want 2", lat); end
`else
    n_cmp++; if (lat != 34) begin n_fail++; $display("FAIL zero_mul_latency: got %0d want 34", lat); end
`endif
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_handshake();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
